// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch-PC control logic.
//   RESET_PC    : word address (PC[31:2]) loaded on reset
//   EXC_PC      : word address of the exception handler entry
//   pc_t        : word-address PC type, bits [31:2] of the byte address
//   redir_src_e : which request won redirect arbitration this cycle
//   state_e     : fetch-handshake state (RUN normal, DROP discarding a fetch)
package cpu_pkg;

   localparam logic [29:0] RESET_PC = 30'h00000C00;
   localparam logic [29:0] EXC_PC   = 30'h00001060;

   typedef logic [31:2] pc_t;

   typedef enum logic [1:0] {
      R_NONE,
      R_JUMP,
      R_ERET,
      R_EXC
   } redir_src_e;

   typedef enum logic {
      RUN,
      DROP
   } state_e;

endpackage

// File: rtl/pc_redirect_ctrl_redir_arb.sv
// Redirect arbiter: purely combinational priority select, target mux and
// flush decode for the fetch PC.
// Ports:
//   stall        in   hazard stall; suppresses ID jumps only
//   jump_req/pc  in   ID-stage taken jump/branch and its target
//   eret_req/epc in   ERET committing and its return PC
//   exc_req      in   exception committing (target is EXC_PC)
//   src          out  winning request (R_NONE when nothing redirects)
//   target       out  winning target PC (don't-care when src == R_NONE)
//   flush_*      out  per-stage kill strobes for the winning request
module redir_arb
   import cpu_pkg::*;
#(
   parameter logic [29:0] EXC_TARGET = cpu_pkg::EXC_PC
) (
   input  logic        stall,
   input  logic        jump_req,
   input  logic [29:0] jump_pc,
   input  logic        eret_req,
   input  logic [29:0] epc,
   input  logic        exc_req,
   output redir_src_e  src,
   output logic [29:0] target,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        flush_exmem
);

   // NOTE: every output gets a default before the priority chain so no
   // path leaves a signal unassigned, which would infer a latch.
   always_comb begin
      src         = R_NONE;
      target      = jump_pc;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_exmem = 1'b0;
      if (exc_req) begin
         // Exception kills everything younger than the faulting MEM-stage instruction.
         src         = R_EXC;
         target      = EXC_TARGET;
         flush_ifid  = 1'b1;
         flush_idex  = 1'b1;
         flush_exmem = 1'b1;
      end else if (eret_req) begin
         src        = R_ERET;
         target     = epc;
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
      end else if (jump_req && !stall) begin
         // A stalled ID stage has not really resolved its jump yet.
         src        = R_JUMP;
         target     = jump_pc;
         flush_ifid = 1'b1;
      end
   end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: sequences sequential advance, ID jump redirects, ERET
// returns and exception entry, and tracks the instruction-memory handshake
// so that a redirect arriving while a fetch is outstanding is deferred until
// that fetch returns (the memory cannot cancel it).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall                      hold PC and IF/ID
//   jump_req, jump_pc          ID-stage redirect
//   eret_req, epc              ERET return
//   exc_req                    exception entry
//   imem_req, imem_addr        fetch request and word address (= pc)
//   imem_rdy                   fetch data valid this cycle
//   if_valid                   fetched word accepted into IF/ID
//   pc                         current fetch PC
//   flush_ifid/idex/exmem      one-cycle stage kill strobes
//   busy_drop                  discarding a stale outstanding fetch
module pc_redirect_ctrl
   import cpu_pkg::*;
#(
   parameter logic [29:0] RESET_PC = cpu_pkg::RESET_PC,
   parameter logic [29:0] EXC_PC   = cpu_pkg::EXC_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        jump_req,
   input  logic [29:0] jump_pc,
   input  logic        eret_req,
   input  logic [29:0] epc,
   input  logic        exc_req,
   output logic        imem_req,
   output logic [29:0] imem_addr,
   input  logic        imem_rdy,
   output logic        if_valid,
   output logic [29:0] pc,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        flush_exmem,
   output logic        busy_drop
);

   state_e      state;
   pc_t         pc_q;
   pc_t         pend_pc;
   redir_src_e  src;
   logic [29:0] target;
   logic        redir;

   redir_arb #(
      .EXC_TARGET (EXC_PC)
   ) u_arb (
      .stall       (stall),
      .jump_req    (jump_req),
      .jump_pc     (jump_pc),
      .eret_req    (eret_req),
      .epc         (epc),
      .exc_req     (exc_req),
      .src         (src),
      .target      (target),
      .flush_ifid  (flush_ifid),
      .flush_idex  (flush_idex),
      .flush_exmem (flush_exmem)
   );

   assign redir     = (src != R_NONE);
   assign pc        = pc_q;
   assign imem_addr = pc_q;
   // A fetch is always in flight; the memory paces progress through imem_rdy.
   assign imem_req  = 1'b1;
   assign busy_drop = (state == DROP);
   // Flushes and if_valid must land in the same cycle as the request that
   // causes them, so they are decoded combinationally rather than registered.
   // Any redirect already kills the returning word, so if_valid never meets flush_ifid.
   assign if_valid  = (state == RUN) && !redir && imem_rdy && !stall;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         pc_q    <= RESET_PC;
         pend_pc <= '0;
      end else begin
         case (state)
            RUN: begin
               if (redir) begin
                  if (imem_rdy) begin
                     pc_q <= target;
                  end else begin
                     // Fetch at the old PC still outstanding: park the target.
                     pend_pc <= target;
                     state   <= DROP;
                  end
               end else if (imem_rdy && !stall) begin
                  pc_q <= pc_q + 30'd1;
               end
            end
            DROP: begin
               if (imem_rdy) begin
                  // Stale word returns and is discarded; a same-cycle redirect wins over the parked one.
                  pc_q  <= redir ? target : pend_pc;
                  state <= RUN;
               end else if (redir) begin
                  pend_pc <= target;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios plus random
// traffic compared against a behavioural model of the fetch-PC rules.
module tb_pc_redirect_ctrl;

   localparam logic [29:0] RST_PC = 30'h00000C00;
   localparam logic [29:0] EXC_PC = 30'h00001060;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        jump_req;
   logic [29:0] jump_pc;
   logic        eret_req;
   logic [29:0] epc;
   logic        exc_req;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic        imem_rdy;
   logic        if_valid;
   logic [29:0] pc;
   logic        flush_ifid;
   logic        flush_idex;
   logic        flush_exmem;
   logic        busy_drop;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [29:0] m_pc;
   logic [29:0] m_pend;
   bit          m_drop;

   // Expected outputs for the cycle currently being driven
   logic [29:0] exp_pc;
   logic        exp_ifv;
   logic        exp_fi;
   logic        exp_fd;
   logic        exp_fe;
   logic        exp_busy;

   pc_redirect_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .jump_req    (jump_req),
      .jump_pc     (jump_pc),
      .eret_req    (eret_req),
      .epc         (epc),
      .exc_req     (exc_req),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdy    (imem_rdy),
      .if_valid    (if_valid),
      .pc          (pc),
      .flush_ifid  (flush_ifid),
      .flush_idex  (flush_idex),
      .flush_exmem (flush_exmem),
      .busy_drop   (busy_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_pc   = RST_PC;
      m_pend = '0;
      m_drop = 0;
   endtask

   // Drive one cycle of inputs after the falling edge, predict this cycle's
   // outputs and the model's next state, then settle for sampling.
   task automatic apply(input logic s, input logic j, input logic [29:0] jp,
                        input logic e, input logic [29:0] ep, input logic x,
                        input logic r);
      bit          any_redir;
      logic [29:0] tgt;
      @(negedge clk);
      stall = s; jump_req = j; jump_pc = jp;
      eret_req = e; epc = ep; exc_req = x; imem_rdy = r;
      any_redir = x || e || (j && !s);
      if (x)      tgt = EXC_PC;
      else if (e) tgt = ep;
      else        tgt = jp;
      exp_pc   = m_pc;
      exp_busy = m_drop;
      exp_fi   = any_redir;
      exp_fd   = x || e;
      exp_fe   = x;
      exp_ifv  = !m_drop && !any_redir && r && !s;
      if (m_drop) begin
         if (any_redir) m_pend = tgt;
         if (r) begin
            m_pc   = m_pend;
            m_drop = 0;
         end
      end else if (any_redir) begin
         if (r) m_pc = tgt;
         else begin
            m_pend = tgt;
            m_drop = 1;
         end
      end else if (r && !s) begin
         m_pc = m_pc + 30'd1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      stall = 0; jump_req = 0; jump_pc = '0; eret_req = 0;
      epc = '0; exc_req = 0; imem_rdy = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      #12;
      checks++;
      if (pc !== RST_PC) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, RST_PC); end
      checks++;
      if ({if_valid, flush_ifid, flush_idex, flush_exmem, busy_drop} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=00000",
                  {if_valid, flush_ifid, flush_idex, flush_exmem, busy_drop});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_imem_req got=%b exp=1", imem_req); end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) begin
         apply(0, 0, '0, 0, '0, 0, 1);
         checks++;
         if (pc !== RST_PC + 30'(i) || imem_addr !== pc) begin
            errors++;
            $display("FAIL seq_pc[%0d] got=%h addr=%h exp=%h", i, pc, imem_addr, RST_PC + 30'(i));
         end
         checks++;
         if (if_valid !== 1'b1 || flush_ifid !== 1'b0) begin
            errors++;
            $display("FAIL seq_valid[%0d] got ifv=%b fi=%b exp ifv=1 fi=0", i, if_valid, flush_ifid);
         end
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 2; i++) begin
         apply(1, 1, 30'h100, 0, '0, 0, 1);
         checks++;
         if (pc !== exp_pc || if_valid !== 1'b0 || flush_ifid !== 1'b0) begin
            errors++;
            $display("FAIL stall[%0d] got pc=%h ifv=%b fi=%b exp pc=%h ifv=0 fi=0",
                     i, pc, if_valid, flush_ifid, exp_pc);
         end
      end
      apply(0, 0, '0, 0, '0, 0, 0);
      checks++;
      if (pc !== exp_pc) begin errors++; $display("FAIL stall_hold got=%h exp=%h", pc, exp_pc); end
   endtask

   task automatic test_priority();
      apply(0, 1, 30'h100, 1, 30'h200, 1, 1);
      checks++;
      if ({flush_ifid, flush_idex, flush_exmem, if_valid} !== 4'b1110) begin
         errors++;
         $display("FAIL prio_flush got=%b exp=1110", {flush_ifid, flush_idex, flush_exmem, if_valid});
      end
      apply(0, 0, '0, 0, '0, 0, 1);
      checks++;
      if (pc !== EXC_PC) begin errors++; $display("FAIL prio_pc got=%h exp=%h", pc, EXC_PC); end
      checks++;
      if ({flush_ifid, flush_idex, flush_exmem} !== 3'b000) begin
         errors++;
         $display("FAIL prio_flush_width got=%b exp=000", {flush_ifid, flush_idex, flush_exmem});
      end
      // ERET beats jump
      apply(0, 1, 30'h100, 1, 30'h200, 0, 1);
      checks++;
      if ({flush_ifid, flush_idex, flush_exmem} !== 3'b110) begin
         errors++;
         $display("FAIL eret_flush got=%b exp=110", {flush_ifid, flush_idex, flush_exmem});
      end
      apply(0, 0, '0, 0, '0, 0, 0);
      checks++;
      if (pc !== 30'h200) begin errors++; $display("FAIL eret_pc got=%h exp=200", pc); end
   endtask

   task automatic test_drop();
      apply(0, 1, 30'h100, 0, '0, 0, 0);
      checks++;
      if (flush_ifid !== 1'b1 || busy_drop !== 1'b0) begin
         errors++;
         $display("FAIL drop_enter got fi=%b busy=%b exp fi=1 busy=0", flush_ifid, busy_drop);
      end
      apply(0, 0, '0, 1, 30'h345, 0, 0);
      checks++;
      if (busy_drop !== 1'b1 || flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin
         errors++;
         $display("FAIL drop_eret got busy=%b fi=%b fd=%b exp 1 1 1", busy_drop, flush_ifid, flush_idex);
      end
      apply(0, 0, '0, 0, '0, 0, 1);
      checks++;
      if (busy_drop !== 1'b1 || if_valid !== 1'b0) begin
         errors++;
         $display("FAIL drop_discard got busy=%b ifv=%b exp busy=1 ifv=0", busy_drop, if_valid);
      end
      apply(0, 0, '0, 0, '0, 0, 1);
      checks++;
      if (pc !== 30'h345 || busy_drop !== 1'b0 || if_valid !== 1'b1) begin
         errors++;
         $display("FAIL drop_exit got pc=%h busy=%b ifv=%b exp pc=345 busy=0 ifv=1", pc, busy_drop, if_valid);
      end
   endtask

   task automatic test_wrap();
      apply(0, 1, 30'h3FFFFFFF, 0, '0, 0, 1);
      apply(0, 0, '0, 0, '0, 0, 1);
      checks++;
      if (pc !== 30'h3FFFFFFF) begin errors++; $display("FAIL wrap_top got=%h exp=3fffffff", pc); end
      apply(0, 0, '0, 0, '0, 0, 1);
      checks++;
      if (pc !== 30'h0) begin errors++; $display("FAIL wrap_zero got=%h exp=0", pc); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         apply($urandom_range(3) == 0, $urandom_range(3) == 0, 30'($urandom),
               $urandom_range(9) == 0, 30'($urandom), $urandom_range(15) == 0,
               $urandom_range(2) != 0);
         checks++;
         if (pc !== exp_pc || imem_addr !== exp_pc || if_valid !== exp_ifv || busy_drop !== exp_busy ||
             {flush_ifid, flush_idex, flush_exmem} !== {exp_fi, exp_fd, exp_fe}) begin
            errors++;
            $display("FAIL rand[%0d] got pc=%h ifv=%b busy=%b fl=%b exp pc=%h ifv=%b busy=%b fl=%b",
                     i, pc, if_valid, busy_drop, {flush_ifid, flush_idex, flush_exmem},
                     exp_pc, exp_ifv, exp_busy, {exp_fi, exp_fd, exp_fe});
         end
      end
   endtask

   task automatic test_reset_mid_drop();
      apply(0, 1, 30'h0ABC, 0, '0, 0, 0);
      apply(0, 0, '0, 0, '0, 0, 0);
      checks++;
      if (busy_drop !== 1'b1) begin errors++; $display("FAIL mid_drop_enter got=%b exp=1", busy_drop); end
      #2;
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (pc !== RST_PC || busy_drop !== 1'b0 || if_valid !== 1'b0 || flush_ifid !== 1'b0) begin
         errors++;
         $display("FAIL mid_drop_reset got pc=%h busy=%b ifv=%b fi=%b exp pc=%h 0 0 0",
                  pc, busy_drop, if_valid, flush_ifid, RST_PC);
      end
      @(negedge clk);
      rst_n = 1'b1;
      apply(0, 0, '0, 0, '0, 0, 1);
      checks++;
      if (pc !== RST_PC || if_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_drop_refetch got pc=%h ifv=%b exp pc=%h ifv=1", pc, if_valid, RST_PC);
      end
      apply(0, 0, '0, 0, '0, 0, 0);
      checks++;
      if (pc !== RST_PC + 30'd1) begin errors++; $display("FAIL mid_drop_advance got=%h exp=%h", pc, RST_PC + 30'd1); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_priority();
      test_drop();
      test_wrap();
      test_random();
      test_reset_mid_drop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
